// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-address generator with branch resolution and redirect buffer
//
// Owns the fetch PC. Resolves D-stage branches and jumps, applies exception and
// ERET redirects, and holds one pending redirect target while instruction
// memory is busy, so the delay slot is always accepted before the target.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   stall_i           hazard stall: freezes PC, ignores D-stage redirect
//   imem_ready_i      instruction memory accepts pc_o this cycle
//   d_valid_i         D-stage instruction valid
//   d_kind_i          control-transfer kind (0 NONE .. 8 JR/JALR)
//   d_pc_i            PC of the D-stage instruction
//   d_imm_i           branch immediate
//   d_index_i         jump instr_index
//   d_rs_i, d_rt_i    forwarded register operands
//   exc_req_i         exception entry pulse
//   eret_i            ERET pulse
//   epc_i             ERET return address
//   pc_o              current fetch address
//   imem_req_o        fetch request
//   taken_o           D-stage transfer resolves taken (combinational)
//   link_o            d_pc_i + 8 (combinational)
//   redirect_drop_o   one-cycle pulse: redirect discarded, one already pending
//   fetch_adel_o      pc_o misaligned
module pc_gen #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              imem_ready_i,
  input  logic              d_valid_i,
  input  logic [3:0]        d_kind_i,
  input  logic [ADDR_W-1:0] d_pc_i,
  input  logic [15:0]       d_imm_i,
  input  logic [25:0]       d_index_i,
  input  logic [31:0]       d_rs_i,
  input  logic [31:0]       d_rt_i,
  input  logic              exc_req_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              imem_req_o,
  output logic              taken_o,
  output logic [ADDR_W-1:0] link_o,
  output logic              redirect_drop_o,
  output logic              fetch_adel_o
);

  localparam logic [3:0] K_BEQ  = 4'd1;
  localparam logic [3:0] K_BNE  = 4'd2;
  localparam logic [3:0] K_BLEZ = 4'd3;
  localparam logic [3:0] K_BGTZ = 4'd4;
  localparam logic [3:0] K_BLTZ = 4'd5;
  localparam logic [3:0] K_BGEZ = 4'd6;
  localparam logic [3:0] K_J    = 4'd7;
  localparam logic [3:0] K_JR   = 4'd8;

  localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_VEC_A  = EXC_VEC[ADDR_W-1:0];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_v_q, pend_v_d;
  logic              req_q, req_d;
  logic              drop_q, drop_d;

  logic [ADDR_W-1:0] d_pc_plus4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] target;
  logic              cond;
  logic              take;
  logic              adv;

  assign d_pc_plus4 = d_pc_i + ADDR_W'(4);
  assign link_o     = d_pc_i + ADDR_W'(8);
  assign br_off     = {{(ADDR_W-18){d_imm_i[15]}}, d_imm_i, 2'b00};
  assign br_target  = d_pc_plus4 + br_off;
  // J keeps the region bits of the delay-slot address above bit 27.
  assign j_target   = {d_pc_plus4[ADDR_W-1:28], d_index_i, 2'b00};

  always_comb begin
    cond   = 1'b0;
    target = br_target;
    case (d_kind_i)
      K_BEQ:  cond = (d_rs_i == d_rt_i);
      K_BNE:  cond = (d_rs_i != d_rt_i);
      K_BLEZ: cond = ($signed(d_rs_i) <= 32'sd0);
      K_BGTZ: cond = ($signed(d_rs_i) >  32'sd0);
      K_BLTZ: cond = ($signed(d_rs_i) <  32'sd0);
      K_BGEZ: cond = ($signed(d_rs_i) >= 32'sd0);
      K_J: begin
        cond   = 1'b1;
        target = j_target;
      end
      K_JR: begin
        cond   = 1'b1;
        target = d_rs_i[ADDR_W-1:0];
      end
      default: cond = 1'b0;
    endcase
  end

  assign taken_o = d_valid_i & cond;
  assign take    = taken_o & ~stall_i;
  assign adv     = req_q & imem_ready_i & ~stall_i;

  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_v_d  = pend_v_q;
    req_d     = 1'b1;
    drop_d    = 1'b0;
    if (exc_req_i) begin
      // Outstanding fetch is simply abandoned; imem reads have no side effects.
      pc_d     = EXC_VEC_A;
      pend_v_d = 1'b0;
    end else if (eret_i) begin
      pc_d     = epc_i;
      pend_v_d = 1'b0;
    end else if (adv && pend_v_q) begin
      // Pending target wins; a simultaneous take would be lost, so flag it.
      pc_d     = pend_pc_q;
      pend_v_d = 1'b0;
      drop_d   = take;
    end else if (adv && take) begin
      pc_d = target;
    end else if (adv) begin
      pc_d = pc_q + ADDR_W'(4);
    end else if (take && !pend_v_q) begin
      // Delay slot not yet accepted: park the target until it is.
      pend_pc_d = target;
      pend_v_d  = 1'b1;
    end else if (take) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC_A;
      pend_pc_q <= '0;
      pend_v_q  <= 1'b0;
      req_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_v_q  <= pend_v_d;
      req_q     <= req_d;
      drop_q    <= drop_d;
    end
  end

  assign pc_o            = pc_q;
  assign imem_req_o      = req_q;
  assign redirect_drop_o = drop_q;
  assign fetch_adel_o    = |pc_q[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i;
  logic        imem_ready_i;
  logic        d_valid_i;
  logic [3:0]  d_kind_i;
  logic [31:0] d_pc_i;
  logic [15:0] d_imm_i;
  logic [25:0] d_index_i;
  logic [31:0] d_rs_i;
  logic [31:0] d_rt_i;
  logic        exc_req_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic [31:0] pc_o;
  logic        imem_req_o;
  logic        taken_o;
  logic [31:0] link_o;
  logic        redirect_drop_o;
  logic        fetch_adel_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_gen #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_3000),
    .EXC_VEC (32'h0000_4180)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall_i        (stall_i),
    .imem_ready_i   (imem_ready_i),
    .d_valid_i      (d_valid_i),
    .d_kind_i       (d_kind_i),
    .d_pc_i         (d_pc_i),
    .d_imm_i        (d_imm_i),
    .d_index_i      (d_index_i),
    .d_rs_i         (d_rs_i),
    .d_rt_i         (d_rt_i),
    .exc_req_i      (exc_req_i),
    .eret_i         (eret_i),
    .epc_i          (epc_i),
    .pc_o           (pc_o),
    .imem_req_o     (imem_req_o),
    .taken_o        (taken_o),
    .link_o         (link_o),
    .redirect_drop_o(redirect_drop_o),
    .fetch_adel_o   (fetch_adel_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  kind;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_taken;
    logic [31:0] exp_link;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [3:0] k, input logic [31:0] p,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic et, input logic [31:0] el);
    vec_t t;
    t.valid = v; t.kind = k; t.pc = p; t.rs = rs; t.rt = rt;
    t.exp_taken = et; t.exp_link = el;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] k, input logic [31:0] p, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm, input logic [25:0] idx);
    d_valid_i = 1'b1; d_kind_i = k; d_pc_i = p; d_rs_i = rs; d_rt_i = rt;
    d_imm_i = imm; d_index_i = idx;
  endtask

  task automatic clr_d();
    d_valid_i = 1'b0; d_kind_i = 4'd0;
  endtask

  initial begin
    reset_n = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b1;
    d_valid_i = 1'b0; d_kind_i = 4'd0; d_pc_i = 32'h0; d_imm_i = 16'h0;
    d_index_i = 26'h0; d_rs_i = 32'h0; d_rt_i = 32'h0;
    exc_req_i = 1'b0; eret_i = 1'b0; epc_i = 32'h0;

    tick(); tick();
    chk("reset_pc", pc_o, 32'h3000);
    chk("reset_req", {31'h0, imem_req_o}, 32'h0);
    chk("reset_drop", {31'h0, redirect_drop_o}, 32'h0);
    chk("reset_adel", {31'h0, fetch_adel_o}, 32'h0);

    // Combinational resolution table, applied while reset holds the state.
    add(1, 4'd1, 32'h3004, 32'd5, 32'd5, 1, 32'h300C);
    add(1, 4'd1, 32'h3004, 32'd5, 32'd6, 0, 32'h300C);
    add(1, 4'd2, 32'h1000, 32'd5, 32'd5, 0, 32'h1008);
    add(1, 4'd2, 32'h1000, 32'd5, 32'd6, 1, 32'h1008);
    add(1, 4'd3, 32'h2000, 32'hFFFF_FFFF, 32'd0, 1, 32'h2008);
    add(1, 4'd3, 32'h2000, 32'd0, 32'd0, 1, 32'h2008);
    add(1, 4'd3, 32'h2000, 32'd1, 32'd0, 0, 32'h2008);
    add(1, 4'd4, 32'h2000, 32'hFFFF_FFFF, 32'd0, 0, 32'h2008);
    add(1, 4'd4, 32'h2000, 32'd0, 32'd0, 0, 32'h2008);
    add(1, 4'd4, 32'h2000, 32'd1, 32'd0, 1, 32'h2008);
    add(1, 4'd4, 32'h2000, 32'h7FFF_FFFF, 32'd0, 1, 32'h2008);
    add(1, 4'd5, 32'h2000, 32'hFFFF_FFFF, 32'd0, 1, 32'h2008);
    add(1, 4'd5, 32'h2000, 32'd0, 32'd0, 0, 32'h2008);
    add(1, 4'd5, 32'h2000, 32'd1, 32'd0, 0, 32'h2008);
    add(1, 4'd5, 32'h2000, 32'h8000_0000, 32'd0, 1, 32'h2008);
    add(1, 4'd6, 32'h2000, 32'hFFFF_FFFF, 32'd0, 0, 32'h2008);
    add(1, 4'd6, 32'h2000, 32'd0, 32'd0, 1, 32'h2008);
    add(1, 4'd6, 32'h2000, 32'd1, 32'd0, 1, 32'h2008);
    add(1, 4'd7, 32'h3000, 32'd0, 32'd0, 1, 32'h3008);
    add(1, 4'd8, 32'h3000, 32'd0, 32'd0, 1, 32'h3008);
    add(1, 4'd0, 32'h3000, 32'd5, 32'd5, 0, 32'h3008);
    add(1, 4'd9, 32'h3000, 32'd5, 32'd5, 0, 32'h3008);
    add(1, 4'd15, 32'h3000, 32'd5, 32'd5, 0, 32'h3008);
    add(0, 4'd1, 32'h3000, 32'd5, 32'd5, 0, 32'h3008);
    add(1, 4'd7, 32'hFFFF_FFFC, 32'd0, 32'd0, 1, 32'h0000_0004);

    foreach (vecs[i]) begin
      d_valid_i = vecs[i].valid; d_kind_i = vecs[i].kind; d_pc_i = vecs[i].pc;
      d_rs_i = vecs[i].rs; d_rt_i = vecs[i].rt; d_imm_i = 16'h0; d_index_i = 26'h0;
      #1;
      chk($sformatf("taken[%0d]", i), {31'h0, taken_o}, {31'h0, vecs[i].exp_taken});
      chk($sformatf("link[%0d]", i), link_o, vecs[i].exp_link);
    end
    clr_d();

    // Reset release and sequential fetch.
    reset_n = 1'b1;
    tick();
    chk("first_pc", pc_o, 32'h3000);
    chk("first_req", {31'h0, imem_req_o}, 32'h1);
    tick(); chk("run_3004", pc_o, 32'h3004);
    tick(); chk("run_3008", pc_o, 32'h3008);
    chk("run_adel", {31'h0, fetch_adel_o}, 32'h0);

    // BEQ taken, adv coincides: target 0x3004 next cycle.
    set_d(4'd1, 32'h3004, 32'd5, 32'd5, 16'hFFFF, 26'h0);
    #1;
    chk("beq_taken", {31'h0, taken_o}, 32'h1);
    chk("beq_link", link_o, 32'h300C);
    tick(); clr_d();
    chk("beq_target", pc_o, 32'h3004);
    tick(); chk("beq_after", pc_o, 32'h3008);

    // BNE not taken: plain increment.
    set_d(4'd2, 32'h3004, 32'd1, 32'd1, 16'h0010, 26'h0);
    #1;
    chk("bne_nt", {31'h0, taken_o}, 32'h0);
    tick(); clr_d();
    chk("bne_pc", pc_o, 32'h300C);
    tick(); chk("seq_3010", pc_o, 32'h3010);

    // Pending redirect while memory busy, plus a dropped second redirect.
    imem_ready_i = 1'b0;
    set_d(4'd7, 32'h300C, 32'd0, 32'd0, 16'h0, 26'h0000C40);
    tick(); clr_d();
    chk("pend_hold1", pc_o, 32'h3010);
    chk("pend_nodrop", {31'h0, redirect_drop_o}, 32'h0);
    set_d(4'd7, 32'h300C, 32'd0, 32'd0, 16'h0, 26'h0000100);
    tick(); clr_d();
    chk("pend_hold2", pc_o, 32'h3010);
    chk("drop_pulse", {31'h0, redirect_drop_o}, 32'h1);
    tick();
    chk("drop_end", {31'h0, redirect_drop_o}, 32'h0);
    chk("pend_hold3", pc_o, 32'h3010);
    imem_ready_i = 1'b1;
    tick(); chk("pend_target", pc_o, 32'h3100);
    tick(); chk("pend_after", pc_o, 32'h3104);

    // Stalled JR is ignored; same JR unstalled redirects after delay slot.
    stall_i = 1'b1;
    set_d(4'd8, 32'h3100, 32'h0000_4000, 32'd0, 16'h0, 26'h0);
    #1;
    chk("jr_taken_comb", {31'h0, taken_o}, 32'h1);
    tick();
    chk("stall_frozen", pc_o, 32'h3104);
    stall_i = 1'b0;
    tick(); clr_d();
    chk("jr_target", pc_o, 32'h4000);
    tick(); chk("jr_after", pc_o, 32'h4004);

    // Exception beats ERET and clears a pending redirect.
    imem_ready_i = 1'b0;
    set_d(4'd7, 32'h4000, 32'd0, 32'd0, 16'h0, 26'h0000C40);
    tick(); clr_d();
    chk("exc_pre", pc_o, 32'h4004);
    exc_req_i = 1'b1; eret_i = 1'b1; epc_i = 32'h3022;
    tick(); exc_req_i = 1'b0; eret_i = 1'b0;
    chk("exc_vec", pc_o, 32'h4180);
    imem_ready_i = 1'b1;
    tick(); chk("exc_pend_clr", pc_o, 32'h4184);
    eret_i = 1'b1; epc_i = 32'h3022;
    tick(); eret_i = 1'b0;
    chk("eret_pc", pc_o, 32'h3022);
    chk("eret_adel", {31'h0, fetch_adel_o}, 32'h1);

    // Wrap-around.
    eret_i = 1'b1; epc_i = 32'hFFFF_FFFC;
    tick(); eret_i = 1'b0;
    chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
    tick(); chk("wrap_zero", pc_o, 32'h0);

    // Reset mid-operation discards the pending redirect.
    imem_ready_i = 1'b0;
    set_d(4'd7, 32'h0, 32'd0, 32'd0, 16'h0, 26'h0000C40);
    tick(); clr_d();
    reset_n = 1'b0;
    tick();
    chk("mid_reset_pc", pc_o, 32'h3000);
    chk("mid_reset_req", {31'h0, imem_req_o}, 32'h0);
    reset_n = 1'b1; imem_ready_i = 1'b1;
    tick(); chk("mid_rel_pc", pc_o, 32'h3000);
    tick(); chk("mid_no_pend", pc_o, 32'h3004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
